// File: rtl/seg_store_pkg.sv
// rtl/seg_store_pkg.sv - state encoding, address map defaults and the empty-entry constant for the segment store
package seg_store_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} seg_state_t;

   localparam int SEG_DATA_W   = 32;
   localparam int SEG_CLR_ADDR = 5;
   localparam int SEG_X_BASE   = 300;
   localparam int SEG_Y_BASE   = 400;

   localparam logic [SEG_DATA_W-1:0] SEG_EMPTY = '1;
endpackage

// File: rtl/seg_store_arbiter_if.sv
// rtl/seg_store_arbiter_if.sv - CPU write bus and indexed VGA read port of the segment store
interface seg_store_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 7
);
   logic              cpu_we;
   logic [11:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              vga_req;
   logic [IDX_W-1:0]  vga_idx;
   logic              vga_ack;
   logic [DATA_W-1:0] vga_x;
   logic [DATA_W-1:0] vga_y;

   modport master (output cpu_we, cpu_addr, cpu_wdata, vga_req, vga_idx,
                   input  vga_ack, vga_x, vga_y);
   modport slave  (input  cpu_we, cpu_addr, cpu_wdata, vga_req, vga_idx,
                   output vga_ack, vga_x, vga_y);
endinterface

// File: rtl/seg_addr_decode.sv
// rtl/seg_addr_decode.sv - decodes a CPU address into clear, x-entry and y-entry selects plus entry index
module seg_addr_decode
   import seg_store_pkg::*;
#(
   parameter int MAX_SEGS = 100,
   parameter int IDX_W    = 7,
   parameter int CLR_ADDR = SEG_CLR_ADDR,
   parameter int X_BASE   = SEG_X_BASE,
   parameter int Y_BASE   = SEG_Y_BASE
) (
   input  logic [11:0]      addr,
   output logic             is_clr,
   output logic             is_x,
   output logic             is_y,
   output logic [IDX_W-1:0] idx
);
   localparam logic [11:0] CLR_A = 12'(CLR_ADDR);
   localparam logic [11:0] X_LO  = 12'(X_BASE);
   localparam logic [11:0] X_HI  = 12'(X_BASE + MAX_SEGS);
   localparam logic [11:0] Y_LO  = 12'(Y_BASE);
   localparam logic [11:0] Y_HI  = 12'(Y_BASE + MAX_SEGS);

   always_comb begin
      is_clr = (addr == CLR_A);
      is_x   = (addr >= X_LO) && (addr < X_HI);
      is_y   = (addr >= Y_LO) && (addr < Y_HI);
      idx    = IDX_W'(addr - (is_y ? Y_LO : X_LO));
   end
endmodule

// File: rtl/seg_store_arbiter.sv
// rtl/seg_store_arbiter.sv - segment coordinate store with clear sweep, buffered CPU writes and VGA read arbitration
// Optional macro SEG_COUNT_EN adds the seg_count output.
module seg_store_arbiter
   import seg_store_pkg::*;
#(
   parameter int MAX_SEGS = 100,
   parameter int DATA_W   = SEG_DATA_W,
   parameter int CLR_ADDR = SEG_CLR_ADDR,
   parameter int X_BASE   = SEG_X_BASE,
   parameter int Y_BASE   = SEG_Y_BASE,
   parameter int IDX_W    = 7
) (
   input  logic               clock,
   input  logic               reset,
   seg_store_arbiter_if.slave bus,
   output logic               busy,
   output logic               ovf
`ifdef SEG_COUNT_EN
   ,
   output logic [IDX_W:0]     seg_count
`endif
);
   localparam logic [DATA_W-1:0] EMPTY = DATA_W'(SEG_EMPTY);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(MAX_SEGS - 1);
   localparam logic [IDX_W-1:0]  LIMIT = IDX_W'(MAX_SEGS);

   seg_state_t        state, state_nxt;
   logic [IDX_W-1:0]  sweep_idx, sweep_idx_nxt;
   logic [DATA_W-1:0] x_mem [MAX_SEGS];
   logic [DATA_W-1:0] y_mem [MAX_SEGS];

   logic              pend_valid, pend_sel_y;
   logic [IDX_W-1:0]  pend_idx;
   logic [DATA_W-1:0] pend_data;

   logic              dec_clr, dec_x, dec_y;
   logic [IDX_W-1:0]  dec_idx;
   logic              cpu_clr, cpu_store, vga_take;
   logic              wr_x, wr_y;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;

   seg_addr_decode #(
      .MAX_SEGS (MAX_SEGS),
      .IDX_W    (IDX_W),
      .CLR_ADDR (CLR_ADDR),
      .X_BASE   (X_BASE),
      .Y_BASE   (Y_BASE)
   ) u_decode (
      .addr   (bus.cpu_addr),
      .is_clr (dec_clr),
      .is_x   (dec_x),
      .is_y   (dec_y),
      .idx    (dec_idx)
   );

   assign cpu_clr   = bus.cpu_we && dec_clr;
   assign cpu_store = bus.cpu_we && (dec_x || dec_y);
   assign busy      = (state == CLEAR);
   // no grant in the ack cycle, so a held request yields at most one ack per two cycles
   assign vga_take  = bus.vga_req && !bus.vga_ack;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= CLEAR;
         sweep_idx <= '0;
      end else begin
         state     <= state_nxt;
         sweep_idx <= sweep_idx_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sweep_idx_nxt = sweep_idx;
      wr_x          = 1'b0;
      wr_y          = 1'b0;
      wr_idx        = dec_idx;
      wr_data       = bus.cpu_wdata;
      case (state)
         IDLE: begin
            wr_x = cpu_store && dec_x;
            wr_y = cpu_store && dec_y;
         end
         CLEAR: begin
            wr_x    = 1'b1;
            wr_y    = 1'b1;
            wr_idx  = sweep_idx;
            wr_data = EMPTY;
            // a write landing in the final sweep cycle is latched now and must still drain
            if (sweep_idx == LAST) state_nxt = (pend_valid || cpu_store) ? DRAIN : IDLE;
            else                   sweep_idx_nxt = sweep_idx + 1'b1;
         end
         DRAIN: begin
            wr_x      = !pend_sel_y;
            wr_y      = pend_sel_y;
            wr_idx    = pend_idx;
            wr_data   = pend_data;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (cpu_clr) begin
         state_nxt     = CLEAR;
         sweep_idx_nxt = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_x) x_mem[wr_idx] <= wr_data;
      if (wr_y) y_mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_valid  <= 1'b0;
         pend_sel_y  <= 1'b0;
         pend_idx    <= '0;
         pend_data   <= '0;
         ovf         <= 1'b0;
         bus.vga_ack <= 1'b0;
         bus.vga_x   <= EMPTY;
         bus.vga_y   <= EMPTY;
      end else begin
         if (state == DRAIN) pend_valid <= 1'b0;
         if (state != IDLE && cpu_store) begin
            if (pend_valid) begin
               ovf <= 1'b1;
            end else begin
               pend_valid <= 1'b1;
               pend_sel_y <= dec_y;
               pend_idx   <= dec_idx;
               pend_data  <= bus.cpu_wdata;
            end
         end

         bus.vga_ack <= 1'b0;
         if (vga_take && state != IDLE) begin
            bus.vga_ack <= 1'b1;
            bus.vga_x   <= EMPTY;
            bus.vga_y   <= EMPTY;
         end else if (vga_take && !cpu_store) begin
            bus.vga_ack <= 1'b1;
            if (bus.vga_idx < LIMIT) begin
               bus.vga_x <= x_mem[bus.vga_idx];
               bus.vga_y <= y_mem[bus.vga_idx];
            end else begin
               bus.vga_x <= EMPTY;
               bus.vga_y <= EMPTY;
            end
         end
      end
   end

`ifdef SEG_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset || cpu_clr) begin
         seg_count <= '0;
      end else if (wr_x && state != CLEAR && {1'b0, wr_idx} >= seg_count) begin
         seg_count <= {1'b0, wr_idx} + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_seg_store_arbiter.sv
// tb/tb_seg_store_arbiter.sv - directed and randomized checks of seg_store_arbiter against a behavioural model
// Define SEG_COUNT_EN to also check seg_count.
module tb_seg_store_arbiter;
   localparam int          NSEG = 100;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   logic clock = 1'b0;
   logic reset;
   logic busy, ovf;
`ifdef SEG_COUNT_EN
   logic [7:0] seg_count;
`endif

   seg_store_arbiter_if #(.DATA_W(32), .IDX_W(7)) bus ();

   seg_store_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .busy  (busy),
      .ovf   (ovf)
`ifdef SEG_COUNT_EN
      ,
      .seg_count (seg_count)
`endif
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: store contents plus what the block is doing this cycle
   logic [31:0] m_x [NSEG];
   logic [31:0] m_y [NSEG];
   bit          m_sweeping, m_draining, m_pend, m_pend_y, m_ovf, m_ack;
   int          m_sweep_pos, m_pend_i, m_count;
   logic [31:0] m_pend_d, m_vx, m_vy;

   task automatic model_buffer(input bit sel_y, input int i, input logic [31:0] wd);
      if (m_pend) m_ovf = 1'b1;
      else begin
         m_pend   = 1'b1;
         m_pend_y = sel_y;
         m_pend_i = i;
         m_pend_d = wd;
      end
   endtask

   task automatic model_store(input bit sel_y, input int i, input logic [31:0] wd);
      if (sel_y) m_y[7'(i)] = wd;
      else begin
         m_x[7'(i)] = wd;
         if (i + 1 > m_count) m_count = i + 1;
      end
   endtask

   task automatic model_edge(input int rst, input int we, input int addr, input logic [31:0] wd,
                             input int req, input int idx);
      bit clr, store, sel_y, new_ack;
      int i;
      if (rst != 0) begin
         m_sweeping  = 1'b1;
         m_sweep_pos = 0;
         m_draining  = 1'b0;
         m_pend      = 1'b0;
         m_ovf       = 1'b0;
         m_ack       = 1'b0;
         m_vx        = ONES;
         m_vy        = ONES;
         m_count     = 0;
         return;
      end
      clr   = (we != 0) && addr == 5;
      sel_y = addr >= 400 && addr < 500;
      store = (we != 0) && ((addr >= 300 && addr < 400) || sel_y);
      i     = sel_y ? addr - 400 : addr - 300;

      new_ack = 1'b0;
      if (req != 0 && !m_ack) begin
         if (m_sweeping || m_draining) begin
            new_ack = 1'b1;
            m_vx    = ONES;
            m_vy    = ONES;
         end else if (!store) begin
            new_ack = 1'b1;
            m_vx    = (idx < NSEG) ? m_x[7'(idx)] : ONES;
            m_vy    = (idx < NSEG) ? m_y[7'(idx)] : ONES;
         end
      end
      m_ack = new_ack;

      if (m_sweeping) begin
         m_x[7'(m_sweep_pos)] = ONES;
         m_y[7'(m_sweep_pos)] = ONES;
         if (store) model_buffer(sel_y, i, wd);
         m_sweep_pos++;
         if (m_sweep_pos == NSEG) begin
            m_sweeping = 1'b0;
            m_draining = m_pend;
         end
      end else if (m_draining) begin
         model_store(m_pend_y, m_pend_i, m_pend_d);
         if (store) model_buffer(sel_y, i, wd);
         m_pend     = 1'b0;
         m_draining = 1'b0;
      end else if (store) begin
         model_store(sel_y, i, wd);
      end

      if (clr) begin
         m_sweeping  = 1'b1;
         m_sweep_pos = 0;
         m_draining  = 1'b0;
         m_count     = 0;
      end
   endtask

   task automatic cycle(input int rst, input int we, input int addr, input logic [31:0] wd,
                        input int req, input int idx);
      reset         = (rst != 0);
      bus.cpu_we    = (we != 0);
      bus.cpu_addr  = 12'(addr);
      bus.cpu_wdata = wd;
      bus.vga_req   = (req != 0);
      bus.vga_idx   = 7'(idx);
      @(posedge clock);
      model_edge(rst, we, addr, wd, req, idx);
      #1;
      check_eq("busy", 64'(busy), 64'(m_sweeping));
      check_eq("ovf", 64'(ovf), 64'(m_ovf));
      check_eq("vga_ack", 64'(bus.vga_ack), 64'(m_ack));
      if (m_ack) begin
         check_eq("vga_x", 64'(bus.vga_x), 64'(m_vx));
         check_eq("vga_y", 64'(bus.vga_y), 64'(m_vy));
      end
`ifdef SEG_COUNT_EN
      check_eq("seg_count", 64'(seg_count), 64'(m_count));
`endif
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 32'h0, 0, 0);
   endtask

   task automatic write(input int addr, input logic [31:0] wd);
      cycle(0, 1, addr, wd, 0, 0);
   endtask

   task automatic wait_not_busy(output int n);
      n = 0;
      while (busy && n < 300) begin
         idle(1);
         n++;
      end
   endtask

   task automatic vga_read(input int idx, output logic [31:0] rx, output logic [31:0] ry,
                           output int waited);
      waited = 0;
      do begin
         cycle(0, 0, 0, 32'h0, 1, idx);
         waited++;
      end while (!bus.vga_ack && waited < 10);
      if (!bus.vga_ack) check_eq("vga_timeout", 64'(bus.vga_ack), 64'(1));
      rx = bus.vga_x;
      ry = bus.vga_y;
   endtask

   initial begin
      logic [31:0] rx, ry;
      int          n, w;
      bit          req_active;
      int          req_idx, r, addr, we;
      int          bnd [6];

      bnd = '{299, 399, 400, 499, 500, 0};

      cycle(1, 0, 0, 32'h0, 0, 0);
      cycle(1, 0, 0, 32'h0, 0, 0);
      check_eq("rst_busy", 64'(busy), 64'(1));
      check_eq("rst_ovf", 64'(ovf), 64'(0));
      check_eq("rst_ack", 64'(bus.vga_ack), 64'(0));
      check_eq("rst_vga_x", 64'(bus.vga_x), 64'(ONES));
      check_eq("rst_vga_y", 64'(bus.vga_y), 64'(ONES));

      wait_not_busy(n);
      check_eq("sweep_len", 64'(n), 64'(100));
      vga_read(0, rx, ry, w);
      check_eq("empty_x0", 64'(rx), 64'(ONES));
      check_eq("empty_y0", 64'(ry), 64'(ONES));

      write(300, 32'd7);
      write(400, 32'd9);
      vga_read(0, rx, ry, w);
      check_eq("rd_x0", 64'(rx), 64'(7));
      check_eq("rd_y0", 64'(ry), 64'(9));
      check_eq("rd_latency", 64'(w), 64'(1));
      write(299, 32'h1234);
      write(500, 32'h5678);
      vga_read(99, rx, ry, w);
      check_eq("oob_x99", 64'(rx), 64'(ONES));
      check_eq("oob_y99", 64'(ry), 64'(ONES));
      vga_read(0, rx, ry, w);
      check_eq("keep_x0", 64'(rx), 64'(7));
      check_eq("keep_y0", 64'(ry), 64'(9));

      write(5, 32'h0);
      idle(10);
      write(350, 32'd3);
      idle(9);
      write(351, 32'd4);
      check_eq("ovf_set", 64'(ovf), 64'(1));
      wait_not_busy(n);
      idle(1);
      vga_read(50, rx, ry, w);
      check_eq("drain_x50", 64'(rx), 64'(3));
      vga_read(51, rx, ry, w);
      check_eq("drop_x51", 64'(rx), 64'(ONES));

      cycle(0, 1, 302, 32'd5, 1, 2);
      check_eq("wr_wins_ack", 64'(bus.vga_ack), 64'(0));
      cycle(0, 0, 0, 32'h0, 1, 2);
      check_eq("late_ack", 64'(bus.vga_ack), 64'(1));
      check_eq("late_x2", 64'(bus.vga_x), 64'(5));
      idle(1);

      write(5, 32'h0);
      write(310, 32'hAB);
      idle(38);
      cycle(1, 0, 0, 32'h0, 0, 0);
      check_eq("rst_ovf_clr", 64'(ovf), 64'(0));
      wait_not_busy(n);
      check_eq("resweep_len", 64'(n), 64'(100));
      idle(1);
      vga_read(10, rx, ry, w);
      check_eq("pend_lost_x10", 64'(rx), 64'(ONES));

`ifdef SEG_COUNT_EN
      write(304, 32'd1);
      write(301, 32'd2);
      write(410, 32'd3);
      check_eq("seg_count_5", 64'(seg_count), 64'(5));
      write(5, 32'h0);
      check_eq("seg_count_clr", 64'(seg_count), 64'(0));
      wait_not_busy(n);
      idle(1);
`endif

      req_active = 1'b0;
      req_idx    = 0;
      for (int c = 0; c < 5000; c++) begin
         if (bus.vga_ack) req_active = 1'b0;
         if (!req_active && $urandom_range(0, 2) == 0) begin
            req_active = 1'b1;
            req_idx    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127))
                                                     : int'($urandom_range(0, 99));
         end
         we = int'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 199));
         if (r == 0)        addr = 5;
         else if (r < 80)   addr = 300 + int'($urandom_range(0, 99));
         else if (r < 150)  addr = 400 + int'($urandom_range(0, 99));
         else if (r < 180)  addr = bnd[$urandom_range(0, 5)];
         else               addr = int'($urandom_range(6, 4095));
         cycle(0, we, addr, $urandom, req_active ? 1 : 0, req_idx);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
